laser_search_pn: RTL and testbench
==================================

// Module: laser_search_pn
// PURPOSE
//  Parametrised successor of the two-circle coverage search engine. Loads NPTS
//  target points, then runs an LFSR-driven hill-climb over candidate centre
//  pairs for ROUNDS evaluations. Reports the best pair found and its cover count.
//  Sits between the point-stream source and the result collector.
// PARAMETERS
//  CW        4        coordinate width; grid is 0..2^CW-1 on both axes
//  NPTS      40       points per dataset (>=2)
//  RADIUS    4        circle radius; covered iff dx*dx+dy*dy <= RADIUS*RADIUS
//  ROUNDS    64       candidate evaluations per dataset (>=1)
//  STEP_MAX  3        max per-axis step of one walk move (1..2^CW-1)
//  LFSR_SEED 16'hACE1 reset value of LFSR (nonzero)
// PORTS
//  CLK       in   1          clock, rising edge
//  RST       in   1          reset, synchronous, active-high
//  IN_VALID  in   1          X/Y carry a point this cycle
//  X, Y      in   CW         point coordinates
//  C1X, C1Y  out  CW         best centre 1
//  C2X, C2Y  out  CW         best centre 2
//  COVER     out  $clog2(NPTS+1)  points covered by best pair
//  DONE      out  1          one-cycle pulse; C*/COVER valid
// BEHAVIOUR
//  Reset: state READ, point count 0, C*/COVER/DONE=0, LFSR=LFSR_SEED; RST in any
//   state (mid-READ/EVAL) discards all stored points and restarts in READ.
//  LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1; advances every cycle.
//  READ: point stored when IN_VALID=1 (gaps allowed); after the NPTS-th point ->
//   EVAL. Candidate=best=(mid,mid),(mid,mid), mid=2^(CW-1)-1; best_cover=0.
//  EVAL: NPTS cycles, one stored point per cycle; point counted once if inside
//   either circle. Squares computed at 2*CW+1 bits, no overflow. -> UPDATE.
//  UPDATE (1 cycle): if cand_cover > best_cover (strict; ties keep older) best
//   <= candidate. Next candidate = base pair + per-coordinate offset from LFSR,
//   offset in [-STEP_MAX,+STEP_MAX], saturated to [0,2^CW-1] (never wraps).
//   Base = best pair. Round counter++; at ROUNDS -> OUT, else -> EVAL.
//  First evaluation is the initial (mid,mid) candidate itself.
//  OUT (1 cycle): C*/COVER <= best; DONE=1; -> READ for next dataset.
//   C*/COVER hold value outside OUT.
//  Latency: DONE high exactly ROUNDS*(NPTS+1)+1 cycles after the edge that
//   accepts the last point. IN_VALID ignored outside READ; no back-pressure.
//  COVER monotonic non-decreasing within a dataset (best only).
// CONFIGURATION
//  LASER_ANNEAL_EN defined: separate "current" pair kept; in UPDATE a
//   non-improving candidate becomes current (walk base) when LFSR[2:0]==3'b000
//   (1/8 prob.); best still updated only on strict improvement; base = current.
//  Undefined: no current registers; base = best (pure hill-climb).
//  Latency, ports and reported best identical in both builds.
// TESTING
//  1 RST held 3 cycles -> C*=0, COVER=0, DONE=0; no DONE while IN_VALID=0.
//  2 defaults, 40 points all (7,7), IN_VALID=1 -> DONE pulse at cycle
//    64*41+1=2625 after last point, COVER=40, DONE width 1.
//  3 20 pts at (2,2), 20 at (13,13), ROUNDS=256 -> COVER=40, one centre within
//    radius of each cluster.
//  4 IN_VALID toggled 1/0 every cycle while loading -> same result/latency
//    (counted from last accepted point) as back-to-back load with same seed.
//  5 RST asserted 10 cycles into EVAL -> DONE stays 0; fresh 40-point load
//    then completes normally with correct COVER.
//  6 pts at (0,0),(15,15),(0,15),(15,0) -> all C* in 0..15 every round (probe
//    candidate); no wrap to opposite edge; COVER never decreases.

Source files
------------

// File: rtl/laser_search_pn.sv
// rtl/laser_search_pn.sv - two-circle coverage search: point load, LFSR-driven hill-climb, best-pair report
// Optional build macro LASER_ANNEAL_EN keeps a separate walk base that may accept non-improving moves.
module laser_search_pn #(
  parameter int          CW        = 4,
  parameter int          NPTS      = 40,
  parameter int          RADIUS    = 4,
  parameter int          ROUNDS    = 64,
  parameter int          STEP_MAX  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  input  logic [CW-1:0]              X,
  input  logic [CW-1:0]              Y,
  output logic [CW-1:0]              C1X,
  output logic [CW-1:0]              C1Y,
  output logic [CW-1:0]              C2X,
  output logic [CW-1:0]              C2Y,
  output logic [$clog2(NPTS+1)-1:0]  COVER,
  output logic                       DONE
);

  localparam int          PW   = $clog2(NPTS);
  localparam int          CVW  = $clog2(NPTS+1);
  localparam int          RW   = $clog2(ROUNDS+1);
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [CW-1:0] MID  = CW'((1 << (CW-1)) - 1);
  localparam logic [31:0]   R2   = 32'(RADIUS*RADIUS);
  localparam logic [15:0]   SPAN = 16'(2*STEP_MAX+1);

  typedef enum logic [1:0] {S_READ, S_EVAL, S_UPDATE, S_OUT} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          pt_x [NPTS];
  logic [CW-1:0]          pt_y [NPTS];
  logic [PW-1:0]          cnt, idx;
  logic [RW-1:0]          round_cnt;
  logic [15:0]            lfsr;
  logic [31:0]            rot;
  logic [3:0][CW-1:0]     cand, best, base, next_cand;
  logic [CVW-1:0]         cand_cover, best_cover;
  logic                   accept, load_done, last_pt, last_round, improve, hit;

  // Squared distance is formed at 2*CW+1 bits so the worst corner-to-corner case cannot overflow.
  function automatic logic in_circle(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                     input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    logic [2*CW:0] dx, dy;
    dx = (px >= cx) ? {{(CW+1){1'b0}}, px - cx} : {{(CW+1){1'b0}}, cx - px};
    dy = (py >= cy) ? {{(CW+1){1'b0}}, py - cy} : {{(CW+1){1'b0}}, cy - py};
    return 32'(dx*dx + dy*dy) <= R2;
  endfunction

  // Offset in [-STEP_MAX, +STEP_MAX]; the result clamps at the grid edge instead of wrapping.
  function automatic logic [CW-1:0] step_coord(input logic [CW-1:0] b, input logic [15:0] r);
    int s;
    s = int'(b) + int'(r % SPAN) - STEP_MAX;
    if (s < 0) s = 0;
    else if (s > MAXC) s = MAXC;
    return s[CW-1:0];
  endfunction

  assign accept     = (state == S_READ) && IN_VALID;
  assign load_done  = accept && (cnt == PW'(NPTS-1));
  assign last_pt    = (idx == PW'(NPTS-1));
  assign last_round = (round_cnt == RW'(ROUNDS-1));
  assign improve    = (state == S_UPDATE) && (cand_cover > best_cover);
  assign hit        = in_circle(pt_x[idx], pt_y[idx], cand[0], cand[1]) ||
                      in_circle(pt_x[idx], pt_y[idx], cand[2], cand[3]);
  assign rot        = {lfsr, lfsr};

`ifdef LASER_ANNEAL_EN
  logic [3:0][CW-1:0] cur;
  assign base = (improve || (lfsr[2:0] == 3'b000)) ? cand : cur;
`else
  assign base = improve ? cand : best;
`endif

  always_comb begin
    next_cand = '0;
    for (int k = 0; k < 4; k++) begin
      next_cand[k] = step_coord(base[k], rot[4*k +: 16]);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_READ:   if (load_done) state_nx = S_EVAL;
      S_EVAL:   if (last_pt) state_nx = S_UPDATE;
      S_UPDATE: state_nx = last_round ? S_OUT : S_EVAL;
      S_OUT:    state_nx = S_READ;
      default:  state_nx = S_READ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_READ;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Point storage needs no reset: the load counter alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (accept) begin
      pt_x[cnt] <= X;
      pt_y[cnt] <= Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      round_cnt  <= '0;
      cand       <= '0;
      best       <= '0;
      cand_cover <= '0;
      best_cover <= '0;
      C1X        <= '0;
      C1Y        <= '0;
      C2X        <= '0;
      C2Y        <= '0;
      COVER      <= '0;
      DONE       <= 1'b0;
`ifdef LASER_ANNEAL_EN
      cur        <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_READ: begin
          if (accept) cnt <= load_done ? '0 : cnt + PW'(1);
          if (load_done) begin
            idx        <= '0;
            round_cnt  <= '0;
            cand       <= {4{MID}};
            best       <= {4{MID}};
            cand_cover <= '0;
            best_cover <= '0;
`ifdef LASER_ANNEAL_EN
            cur        <= {4{MID}};
`endif
          end
        end
        S_EVAL: begin
          cand_cover <= cand_cover + CVW'(hit);
          idx        <= last_pt ? '0 : idx + PW'(1);
        end
        S_UPDATE: begin
          if (improve) begin
            best       <= cand;
            best_cover <= cand_cover;
          end
`ifdef LASER_ANNEAL_EN
          cur        <= base;
`endif
          cand       <= next_cand;
          cand_cover <= '0;
          round_cnt  <= round_cnt + RW'(1);
        end
        S_OUT: begin
          C1X   <= best[0];
          C1Y   <= best[1];
          C2X   <= best[2];
          C2Y   <= best[3];
          COVER <= best_cover;
          DONE  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_search_pn.sv
// tb/tb_laser_search_pn.sv - randomized bench for laser_search_pn against a round-level search model
module tb_laser_search_pn;

  localparam int NPTS = 40;
  localparam int SM   = 3;
  localparam int RAD  = 4;
  localparam int MAXC = 15;

  logic       CLK = 1'b0;
  logic       RST, in_valid, sel;
  logic [3:0] x, y;
  logic       iv0, iv3;
  logic [3:0] c1x0, c1y0, c2x0, c2y0, c1x3, c1y3, c2x3, c2y3;
  logic [5:0] cov0, cov3;
  logic       done0, done3;
  logic [3:0] o_c1x, o_c1y, o_c2x, o_c2y;
  logic [5:0] o_cov;
  logic       o_done;

  int n_cmp = 0, n_bad = 0;
  int edges = 0, last_rst = 0;
  int px[$], py[$];
  int m_cov;
  int m_c[4];

  assign iv0    = in_valid & ~sel;
  assign iv3    = in_valid & sel;
  assign o_c1x  = sel ? c1x3 : c1x0;
  assign o_c1y  = sel ? c1y3 : c1y0;
  assign o_c2x  = sel ? c2x3 : c2x0;
  assign o_c2y  = sel ? c2y3 : c2y0;
  assign o_cov  = sel ? cov3 : cov0;
  assign o_done = sel ? done3 : done0;

  laser_search_pn dut (
    .CLK(CLK), .RST(RST), .IN_VALID(iv0), .X(x), .Y(y),
    .C1X(c1x0), .C1Y(c1y0), .C2X(c2x0), .C2Y(c2y0), .COVER(cov0), .DONE(done0)
  );

  laser_search_pn #(.ROUNDS(256)) dut3 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv3), .X(x), .Y(y),
    .C1X(c1x3), .C1Y(c1y3), .C2X(c2x3), .C2Y(c2y3), .COVER(cov3), .DONE(done3)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    edges <= edges + 1;
    if (RST) last_rst <= edges + 1;
  end

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXC) return MAXC;
    return v;
  endfunction

  function automatic int covered(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    for (int i = 0; i < px.size(); i++) begin
      if ((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay) <= RAD*RAD ||
          (px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by) <= RAD*RAD) n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Round-level search: evaluate, keep strict improvements, then random-walk from the best pair.
  // The walk uses the LFSR value held during each round's update cycle.
  task automatic predict(input int rounds, input int e0);
    int cand[4], best[4];
    int bc, cc, t, tgt, w;
    logic [15:0] v;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin cand[k] = 7; best[k] = 7; end
    bc = 0; t = 0; v = 16'hACE1;
    for (int rd = 0; rd < rounds; rd++) begin
      cc = covered(cand[0], cand[1], cand[2], cand[3]);
      if (cc > bc) begin bc = cc; best = cand; end
      tgt = e0 + (rd+1)*(NPTS+1) - 1 - last_rst;
      while (t < tgt) begin v = lfsr_next(v); t++; end
      r = {v, v};
      for (int k = 0; k < 4; k++) begin
        w = int'((r >> (4*k)) & 32'h0000FFFF);
        cand[k] = clamp(best[k] + (w % (2*SM+1)) - SM);
      end
    end
    m_cov = bc;
    m_c   = best;
  endtask

  task automatic load(input int gap, output int e0);
    e0 = 0;
    for (int i = 0; i < NPTS; i++) begin
      in_valid = 1'b1; x = 4'(px[i]); y = 4'(py[i]);
      @(posedge CLK); #1;
      if (i == NPTS-1) e0 = edges;
      else if (gap != 0) begin
        in_valid = 1'b0; x = 4'($urandom_range(0, 15));
        @(posedge CLK); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int rounds, input int e0);
    int lat, exp_lat, obs;
    logic       hold_ok;
    logic [5:0] cov_before;
    predict(rounds, e0);
    exp_lat = rounds*(NPTS+1) + 1;
    lat = -1; hold_ok = 1'b1; cov_before = o_cov;
    for (int k = 1; k <= exp_lat + 50; k++) begin
      @(posedge CLK); #1;
      if (o_done) begin lat = k; break; end
      if (o_cov !== cov_before) hold_ok = 1'b0;
    end
    n_cmp++;
    if (lat != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_cmp++;
    if (!hold_ok) begin n_bad++; $display("FAIL %s cover_hold: got changed before done want held %0d", name, cov_before); end
    n_cmp++;
    if (int'(o_cov) != m_cov) begin n_bad++; $display("FAIL %s cover: got %0d want %0d", name, o_cov, m_cov); end
    n_cmp++;
    if (int'(o_c1x) != m_c[0] || int'(o_c1y) != m_c[1] || int'(o_c2x) != m_c[2] || int'(o_c2y) != m_c[3]) begin
      n_bad++;
      $display("FAIL %s centres: got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)", name,
               o_c1x, o_c1y, o_c2x, o_c2y, m_c[0], m_c[1], m_c[2], m_c[3]);
    end
    obs = covered(int'(o_c1x), int'(o_c1y), int'(o_c2x), int'(o_c2y));
    n_cmp++;
    if (int'(o_cov) != obs) begin n_bad++; $display("FAIL %s cover_consistent: got %0d want %0d", name, o_cov, obs); end
    @(posedge CLK); #1;
    n_cmp++;
    if (o_done !== 1'b0) begin n_bad++; $display("FAIL %s done_width: got %0b want 0", name, o_done); end
  endtask

  task automatic fill_const(input int cx, input int cy, input int n);
    for (int i = 0; i < n; i++) begin px.push_back(cx); py.push_back(cy); end
  endtask

  task automatic fill_random_clusters();
    int ax, ay, bx, by;
    ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
    bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
    px.delete(); py.delete();
    for (int i = 0; i < NPTS; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        px.push_back(clamp(ax + $urandom_range(0, 6) - 3)); py.push_back(clamp(ay + $urandom_range(0, 6) - 3));
      end else begin
        px.push_back(clamp(bx + $urandom_range(0, 6) - 3)); py.push_back(clamp(by + $urandom_range(0, 6) - 3));
      end
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    RST = 1'b1; in_valid = 1'b0; sel = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (c1x0 !== 4'd0) begin n_bad++; $display("FAIL reset_c1x: got %0d want 0", c1x0); end
    n_cmp++; if (c1y0 !== 4'd0) begin n_bad++; $display("FAIL reset_c1y: got %0d want 0", c1y0); end
    n_cmp++; if (c2x0 !== 4'd0) begin n_bad++; $display("FAIL reset_c2x: got %0d want 0", c2x0); end
    n_cmp++; if (c2y0 !== 4'd0) begin n_bad++; $display("FAIL reset_c2y: got %0d want 0", c2y0); end
    n_cmp++; if (cov0 !== 6'd0) begin n_bad++; $display("FAIL reset_cover: got %0d want 0", cov0); end
    n_cmp++; if (done0 !== 1'b0 || done3 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b%0b want 00", done0, done3); end
    RST = 1'b0;
    for (int k = 0; k < 60; k++) begin
      x = 4'($urandom_range(0, 15));
      @(posedge CLK); #1;
      if (done0 || done3) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL idle_no_done: got %0d pulses want 0", seen); end
  endtask

  task automatic test_same_point();
    int e0;
    px.delete(); py.delete();
    fill_const(7, 7, NPTS);
    load(0, e0);
    run_and_check("same_point", 64, e0);
    n_cmp++; if (cov0 !== 6'd40) begin n_bad++; $display("FAIL same_point_full: got %0d want 40", cov0); end
  endtask

  task automatic test_clusters();
    int e0;
    sel = 1'b1;
    px.delete(); py.delete();
    fill_const(2, 2, 20);
    fill_const(13, 13, 20);
    load(0, e0);
    run_and_check("clusters", 256, e0);
    sel = 1'b0;
  endtask

  task automatic test_gapped();
    int e0;
    fill_random_clusters();
    load(1, e0);
    run_and_check("gapped", 64, e0);
  endtask

  task automatic test_back_to_back();
    int e0;
    for (int n = 0; n < 3; n++) begin
      fill_random_clusters();
      load(0, e0);
      run_and_check("back_to_back", 64, e0);
    end
  endtask

  task automatic test_reset_mid_eval();
    int e0, seen = 0;
    fill_random_clusters();
    load(0, e0);
    repeat (10) @(posedge CLK);
    #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    for (int k = 0; k < 64*(NPTS+1) + 20; k++) begin
      @(posedge CLK); #1;
      if (done0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    fill_random_clusters();
    load(0, e0);
    run_and_check("after_abort", 64, e0);
  endtask

  task automatic test_corners();
    int e0;
    px.delete(); py.delete();
    for (int i = 0; i < 10; i++) begin
      px.push_back(0);  py.push_back(0);
      px.push_back(15); py.push_back(15);
      px.push_back(0);  py.push_back(15);
      px.push_back(15); py.push_back(0);
    end
    load(0, e0);
    run_and_check("corners", 64, e0);
  endtask

  initial begin
    test_reset();
    test_same_point();
    test_clusters();
    test_gapped();
    test_back_to_back();
    test_reset_mid_eval();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
